// File: rtl/product_shift_register_if.sv
// Handshake and operand/product bundle for the shift-add product register.
// The ovf signal exists only when PRODUCT_OVF_EN is defined.
interface product_shift_register_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [WIDTH-1:0]     Multiplier_in;
   logic [WIDTH-1:0]     Multiplicand_in;
   logic [2*WIDTH-1:0]   Product_out;
   logic                 busy;
   logic                 done;
`ifdef PRODUCT_OVF_EN
   logic                 ovf;

   modport master (
      output start, Multiplier_in, Multiplicand_in,
      input  Product_out, busy, done, ovf
   );

   modport slave (
      input  start, Multiplier_in, Multiplicand_in,
      output Product_out, busy, done, ovf
   );
`else
   modport master (
      output start, Multiplier_in, Multiplicand_in,
      input  Product_out, busy, done
   );

   modport slave (
      input  start, Multiplier_in, Multiplicand_in,
      output Product_out, busy, done
   );
`endif
endinterface

// File: rtl/product_shift_register.sv
// Sequential unsigned shift-add multiplier product register: WIDTH add/shift
// iterations per operation. Optional overflow flag under PRODUCT_OVF_EN.
module product_shift_register #(
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     Reset,
   product_shift_register_if.slave  mul
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [2*WIDTH-1:0]   p;
   logic [2*WIDTH-1:0]   p_step;
   logic [CNT_W-1:0]     cnt;
   logic                 accept;
   logic                 last;
   logic                 busy;
   logic                 done;

   // One iteration: conditional add into the upper half, carry kept as the
   // extra MSB of the sum so it falls into P[2W-1] on the same-edge shift.
   function automatic logic [2*WIDTH-1:0] add_shift(
      input logic [2*WIDTH-1:0] prod,
      input logic [WIDTH-1:0]   mcand
   );
      logic [WIDTH:0] sum;
      sum = {1'b0, prod[2*WIDTH-1:WIDTH]};
      if (prod[0]) begin
         sum = sum + {1'b0, mcand};
      end
      return {sum, prod[WIDTH-1:1]};
   endfunction

   assign accept = (state == IDLE) && mul.start;
   assign last   = (state == RUN) && (cnt == CNT_LAST);
   assign p_step = add_shift(p, mul.Multiplicand_in);

   always_ff @(posedge clk) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (mul.start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         p   <= '0;
         cnt <= '0;
      end else if (accept) begin
         p   <= {{WIDTH{1'b0}}, mul.Multiplier_in};
         cnt <= '0;
      end else if (state == RUN) begin
         p   <= p_step;
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign mul.Product_out = p;
   assign mul.busy        = busy;
   assign mul.done        = done;

`ifdef PRODUCT_OVF_EN
   logic ovf;

   // Flag sampled from the final product as the FSM enters DONE.
   always_ff @(posedge clk) begin
      if (Reset) begin
         ovf <= 1'b0;
      end else if (accept) begin
         ovf <= 1'b0;
      end else if (last) begin
         ovf <= |p_step[2*WIDTH-1:WIDTH];
      end
   end

   assign mul.ovf = ovf;
`endif

endmodule

// File: tb/tb_product_shift_register.sv
// Bench for product_shift_register: abstract multiply model checked every
// cycle, plus directed operations with literal expected products.
module tb_product_shift_register;

   localparam int W = 32;

   logic clk = 1'b0;
   logic Reset;

   product_shift_register_if #(.WIDTH(W)) bus();

   product_shift_register #(.WIDTH(W)) dut (
      .clk   (clk),
      .Reset (Reset),
      .mul   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: phase 0 idle, 1 running, 2 done; k iterations completed.
   int             m_phase;
   int             m_k;
   logic [W-1:0]   m_a;
   logic [W-1:0]   m_b;
   logic           m_ovf;
   bit             chk_en = 1'b0;

   task automatic check(input string name, input logic [2*W-1:0] act,
                        input logic [2*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // After k iterations the top holds (low k multiplier bits * b) aligned to
   // bit W-k, and the unconsumed multiplier bits sit below it.
   function automatic logic [2*W-1:0] model_p(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input int k);
      logic [2*W-1:0] mask;
      logic [2*W-1:0] lo;
      mask = ((2*W)'(1) << k) - (2*W)'(1);
      lo   = {{W{1'b0}}, a} & mask;
      return ((lo * {{W{1'b0}}, b}) << (W - k)) | ({{W{1'b0}}, a} >> k);
   endfunction

   always @(posedge clk) begin
      if (Reset) begin
         m_phase <= 0;
         m_k     <= 0;
         m_a     <= '0;
         m_b     <= '0;
         m_ovf   <= 1'b0;
      end else begin
         case (m_phase)
            0: if (bus.start) begin
               m_phase <= 1;
               m_k     <= 0;
               m_a     <= bus.Multiplier_in;
               m_b     <= bus.Multiplicand_in;
               m_ovf   <= 1'b0;
            end
            1: begin
               m_k <= m_k + 1;
               if (m_k + 1 == W) begin
                  m_phase <= 2;
                  m_ovf   <= ((model_p(m_a, m_b, W) >> W) != 0);
               end
            end
            default: m_phase <= 0;
         endcase
      end
   end

   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("busy", bus.busy, (m_phase == 1));
         check("done", bus.done, (m_phase == 2));
         check("product", bus.Product_out, model_p(m_a, m_b, m_k));
`ifdef PRODUCT_OVF_EN
         check("ovf", bus.ovf, m_ovf);
`endif
         if (m_phase == 1) check("mcand_stable_protocol", bus.Multiplicand_in, m_b);
      end
   end

   task automatic wait_done(input string name, input int bound, output int n);
      n = 0;
      while (n < bound) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.done) break;
      end
      check({name, "_latency"}, n, W);
   endtask

   task automatic do_op(input string name, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp,
                        input logic exp_ovf);
      int n;
      @(negedge clk);
      bus.start           = 1'b1;
      bus.Multiplier_in   = a;
      bus.Multiplicand_in = b;
      @(negedge clk);
      bus.start         = 1'b0;
      bus.Multiplier_in = $urandom;
      wait_done(name, W + 8, n);
      check({name, "_product"}, bus.Product_out, exp);
`ifdef PRODUCT_OVF_EN
      check({name, "_ovf"}, bus.ovf, exp_ovf);
`endif
      $display("op %s complete, product=0x%0h expect_ovf=%0d", name, bus.Product_out, exp_ovf);
      @(posedge clk);
   endtask

   initial begin
      int dones;
      int n;
      logic busy_again;

      Reset               = 1'b1;
      bus.start           = 1'b0;
      bus.Multiplier_in   = '0;
      bus.Multiplicand_in = '0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
      check("reset_product", bus.Product_out, 0);
      @(negedge clk);
      Reset = 1'b0;

      do_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0);
      do_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1);
      do_op("zero", 32'd0, 32'h1234_5678, 64'h0, 1'b0);
      do_op("2p16sq", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1);

      // start held high through RUN and DONE
      @(negedge clk);
      bus.start           = 1'b1;
      bus.Multiplier_in   = 32'h21;
      bus.Multiplicand_in = 32'd3;
      dones      = 0;
      busy_again = 1'b0;
      for (int e = 0; e <= W + 2; e++) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
         if (e == W + 2) busy_again = bus.busy;
      end
      check("held_start_done_count", dones, 1);
      check("held_start_reaccept", busy_again, 1'b1);
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("held_second", 2 * W, n);
      check("held_second_product", bus.Product_out, 64'h63);
      @(posedge clk);

      // Reset after iteration 10
      @(negedge clk);
      bus.start           = 1'b1;
      bus.Multiplier_in   = 32'hFFFF_FFFF;
      bus.Multiplicand_in = 32'h0000_FFFF;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      Reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrun_reset_busy", bus.busy, 0);
      check("midrun_reset_product", bus.Product_out, 0);
      check("midrun_reset_done", bus.done, 0);
      @(negedge clk);
      Reset = 1'b0;
      dones = 0;
      repeat (W + 4) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      check("midrun_no_done", dones, 0);

      do_op("7x9", 32'd7, 32'd9, 64'd63, 1'b0);

      // Reset and start together in IDLE
      @(negedge clk);
      Reset               = 1'b1;
      bus.start           = 1'b1;
      bus.Multiplier_in   = 32'd5;
      bus.Multiplicand_in = 32'd5;
      @(posedge clk);
      #1;
      check("reset_start_busy", bus.busy, 0);
      check("reset_start_product", bus.Product_out, 0);
      @(negedge clk);
      Reset     = 1'b0;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check("reset_start_busy_after", bus.busy, 0);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/product_shift_register.md
# product_shift_register

Sequential shift-add product register for the unsigned multiplier datapath. It consumes the multiplicand presented by the upstream multiplicand stage and accumulates the product over WIDTH iterations. Each iteration conditionally adds the multiplicand into the upper half, then shifts the whole product right. A start/busy/done handshake to the surrounding control sequences the operation.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- clk  in  1  rising-edge clock.
- Reset  in  1  reset Reset, synchronous, active-high.
- start  in  1  request a new multiplication; accepted only in IDLE.
- Multiplier_in  in  WIDTH  multiplier; sampled on the accepting edge only.
- Multiplicand_in  in  WIDTH  multiplicand from the upstream stage; sampled every RUN cycle, must stay stable while busy=1.
- Product_out  out  2*WIDTH  product register contents.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE; Product_out is final.
- ovf  out  1  present only with PRODUCT_OVF_EN (see Configuration).

## Operation
- Internal state: product register P[2*WIDTH-1:0], carry bit C, iteration counter cnt of clog2(WIDTH) bits, FSM {IDLE, RUN, DONE}.
- Reset (any state): FSM=IDLE, P=0, C=0, cnt=0, busy=0, done=0, ovf=0.
- IDLE:
  - start=1: P={WIDTH'b0, Multiplier_in}, C=0, cnt=0, go RUN.
  - start=0: hold P.
- RUN, each cycle:
  - If P[0]=1: {C, P[2W-1:W]} = P[2W-1:W] + Multiplicand_in (WIDTH+1-bit unsigned sum). Otherwise C=0 and the upper half is unchanged.
  - Then {C, P} is shifted right one bit logically, so C enters P[2W-1].
  - cnt increments.
  - When cnt==WIDTH-1 on this edge, go DONE. RUN always lasts exactly WIDTH cycles.
- DONE: done=1 for one cycle, P holds, go IDLE unconditionally.
- start while in RUN or DONE is ignored, not queued.
- Product_out = P at all times. It holds the final value through IDLE until the next accepted start overwrites it.
- Arithmetic is unsigned only. The carry out of the add is never lost: it is held in C for the same-edge shift.

## Timing
- Edge 0: start accepted; busy=1 from edge 0 through edge WIDTH.
- Edges 1..WIDTH: one iteration per edge. The FSM enters DONE on edge WIDTH.
- done=1 and Product_out final in the cycle after edge WIDTH, i.e. latency WIDTH cycles from acceptance. DONE lasts one cycle.
- Earliest next acceptance: edge WIDTH+2, since start must be seen in IDLE.
- Reset mid-RUN: on the Reset edge the FSM returns to IDLE with P=0; no done pulse.
- Reset and start in the same cycle: Reset wins.
- Multiplicand_in changing during RUN produces an undefined product; the bench flags it as a protocol violation.

## Configuration
- PRODUCT_OVF_EN defined:
  - Adds the ovf port, registered.
  - On entering DONE, ovf = |P[2W-1:W] (result exceeds WIDTH bits).
  - ovf holds until the next accepted start or Reset, both of which clear it to 0.
- PRODUCT_OVF_EN undefined: the port and its logic are absent; all other behaviour is identical.

## Test plan
- WIDTH=32, Multiplier_in=3, Multiplicand_in=5, start at edge 0 -> busy for 32 edges; done pulses one cycle later with Product_out=0x0000_0000_0000_000F.
- 0xFFFF_FFFF * 0xFFFF_FFFF -> Product_out=0xFFFF_FFFE_0000_0001, exercising carry into P[63]; ovf=1 when enabled.
- Multiplier 0, multiplicand 0x1234_5678 -> Product_out=0 with done at the same latency. Then 0x1_0000 * 0x1_0000 -> 0x0000_0001_0000_0000 and ovf=1.
- start held high throughout RUN and DONE -> exactly one operation completes. The next operation is accepted at the first IDLE cycle, with no extra done pulse.
- Reset asserted after iteration 10 -> next cycle IDLE, Product_out=0, busy=0, no done. A fresh 7*9 then yields 63.
- Reset and start asserted together in IDLE -> the operation is not accepted and busy stays 0.
